// File: rtl/result_digit_splitter.sv
// result_digit_splitter
//   Sequential binary-to-BCD converter feeding the per-digit 7-segment
//   drivers. On an accepted start it runs IN_W shift-add-3 (double-dabble)
//   iterations, then publishes registered digit codes plus per-digit blank
//   and error flags in a single FINISH cycle.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   one-cycle convert request, honoured only in IDLE
//   value     in   [IN_W-1:0] unsigned result, sampled with start
//   err_in    in   upstream error, sampled with start
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when new display outputs are valid
//   digits    out  [4*DIGITS-1:0] BCD codes, digit 0 in bits [3:0]
//   off_bits  out  [DIGITS-1:0] per-digit blank flag
//   err_bits  out  [DIGITS-1:0] per-digit error flag
//
// IN_W must satisfy 2^IN_W-1 < 10^(DIGITS+1) so the guard digit can hold
// any overflow.

module result_digit_splitter_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module result_digit_splitter #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       value,
  input  logic                  err_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     off_bits,
  output logic [DIGITS-1:0]     err_bits
);

  // One guard digit above the displayed ones detects overflow.
  localparam int BW = 4*(DIGITS+1);
  localparam int CW = $clog2(IN_W+1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] sreg;
  logic [BW-1:0]   bcd, bcd_adj;
  logic [CW-1:0]   cnt;
  logic            err_lat;

  logic               ovf, err_any;
  logic [DIGITS-1:0]  fin_off;
  logic               lz;

  // Add-3 correction, one instance per BCD nibble including the guard.
  for (genvar g = 0; g < DIGITS+1; g++) begin : g_adj
    result_digit_splitter_adj3 u_adj (
      .din  (bcd[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(IN_W-1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ovf     = |bcd[4*DIGITS +: 4];
  assign err_any = ovf | err_lat;

  // Leading-zero blank: digit i blanks when it and everything above it is
  // zero. Digit 0 always shows so a zero result reads "0".
  always_comb begin
    lz      = 1'b1;
    fin_off = '0;
    for (int i = DIGITS-1; i >= 1; i--) begin
      lz         = lz & (bcd[4*i +: 4] == 4'd0);
      fin_off[i] = lz;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      bcd      <= '0;
      cnt      <= '0;
      err_lat  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      digits   <= '0;
      off_bits <= {{(DIGITS-1){1'b1}}, 1'b0};
      err_bits <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sreg    <= value;
          bcd     <= '0;
          cnt     <= '0;
          err_lat <= err_in;
          busy    <= 1'b1;
        end
        SHIFT: begin
          {bcd, sreg} <= {bcd_adj[BW-2:0], sreg, 1'b0};
          cnt         <= cnt + CW'(1);
        end
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (err_any) begin
            digits   <= '0;
            off_bits <= '0;
            err_bits <= '1;
          end else begin
            digits   <= bcd[4*DIGITS-1:0];
            off_bits <= fin_off;
            err_bits <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_digit_splitter.sv
module tb_result_digit_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] value;
  logic        err_in;
  logic        busy, done;
  logic [15:0] digits;
  logic [3:0]  off_bits, err_bits;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  result_digit_splitter #(.IN_W(16), .DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value    (value),
    .err_in   (err_in),
    .busy     (busy),
    .done     (done),
    .digits   (digits),
    .off_bits (off_bits),
    .err_bits (err_bits)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic disp(input string tag, input logic [15:0] d, input logic [3:0] o,
                      input logic [3:0] e);
    chk({tag, ".digits"}, {16'h0, digits}, {16'h0, d});
    chk({tag, ".off"},    {28'h0, off_bits}, {28'h0, o});
    chk({tag, ".err"},    {28'h0, err_bits}, {28'h0, e});
  endtask

  // Issues start at the current negedge; pa/pb are sample indices at which
  // a competing start (value 99) is driven. Returns at the negedge where
  // done is seen (or the bound expires).
  task automatic conv(input string tag, input logic [15:0] v, input logic e,
                      input int pa, input int pb);
    int n, bc;
    start = 1'b1; value = v; err_in = e;
    @(negedge clk);
    start = 1'b0; value = 16'($urandom); err_in = ~e;
    n = 0; bc = 0;
    chk({tag, ".done_low"}, {31'h0, done}, 32'h0);
    while (!done && n < 40) begin
      if (busy) bc++;
      start = (n == pa) || (n == pb);
      if (start) value = 16'd99;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, n, 17);
    chk({tag, ".busy_cycles"}, bc, 17);
    chk({tag, ".busy_end"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; value = '0; err_in = 1'b0;
    repeat (3) @(negedge clk);
    disp("rst", 16'h0000, 4'b1110, 4'b0000);
    chk("rst.busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    dc = 0;
    repeat (5) begin @(negedge clk); if (done) dc++; end
    chk("idle.done_count", dc, 0);
    chk("idle.busy", {31'h0, busy}, 32'h0);
    disp("idle", 16'h0000, 4'b1110, 4'b0000);

    // Back-to-back conversions: each start lands on the previous done cycle.
    conv("v1234", 16'd1234, 1'b0, -1, -1);  disp("v1234", 16'h1234, 4'b0000, 4'b0000);
    conv("v7",    16'd7,    1'b0, -1, -1);  disp("v7",    16'h0007, 4'b1110, 4'b0000);
    conv("v0",    16'd0,    1'b0, -1, -1);  disp("v0",    16'h0000, 4'b1110, 4'b0000);
    conv("v305",  16'd305,  1'b0, -1, -1);  disp("v305",  16'h0305, 4'b1000, 4'b0000);
    conv("v10000",16'd10000,1'b0, -1, -1);  disp("v10000",16'h0000, 4'b0000, 4'b1111);
    conv("v65535",16'd65535,1'b0, -1, -1);  disp("v65535",16'h0000, 4'b0000, 4'b1111);
    conv("v9999", 16'd9999, 1'b0, -1, -1);  disp("v9999", 16'h9999, 4'b0000, 4'b0000);
    conv("e42",   16'd42,   1'b1, -1, -1);  disp("e42",   16'h0000, 4'b0000, 4'b1111);
    conv("v42",   16'd42,   1'b0, -1, -1);  disp("v42",   16'h0042, 4'b1100, 4'b0000);

    // Starts during SHIFT and during FINISH are dropped.
    @(negedge clk);
    conv("v11", 16'd11, 1'b0, 5, 16);
    disp("v11", 16'h0011, 4'b1100, 4'b0000);
    dc = 0;
    repeat (20) begin @(negedge clk); if (done || busy) dc++; end
    chk("v11.no_queue", dc, 0);
    disp("v11.hold", 16'h0011, 4'b1100, 4'b0000);

    // Reset in the middle of a conversion; display must not flicker before it.
    start = 1'b1; value = 16'd1234; err_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid.busy", {31'h0, busy}, 32'h1);
    disp("mid.hold", 16'h0011, 4'b1100, 4'b0000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    disp("midrst", 16'h0000, 4'b1110, 4'b0000);
    chk("midrst.busy", {31'h0, busy}, 32'h0);
    chk("midrst.done", {31'h0, done}, 32'h0);
    dc = 0;
    repeat (20) begin @(negedge clk); if (done || busy) dc++; end
    chk("midrst.quiet", dc, 0);

    conv("v5678", 16'd5678, 1'b0, -1, -1);  disp("v5678", 16'h5678, 4'b0000, 4'b0000);
    @(negedge clk);
    chk("v5678.done_drop", {31'h0, done}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_digit_splitter.md
Name: result_digit_splitter

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the per-digit 7-segment drivers in the calculator display path.
- Takes the unsigned calculator result on a start strobe and converts it with an iterative shift-add-3 (double-dabble) engine.
- Presents one registered 4-bit digit code plus one blank flag and one error flag per display position, wired straight to each digit driver's switch, off_bit and error inputs.
- Handles leading-zero blanking and overflow/error indication (error renders as a dash on every digit).

Parameters:
- IN_W, 16: width of the binary result input. Legal only if 2^IN_W-1 < 10^(DIGITS+1).
- DIGITS, 4: number of display positions driven.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to convert value; honoured only in IDLE.
- value  in  IN_W  unsigned binary result; sampled on the accepted start cycle.
- err_in  in  1  upstream calculator error (e.g. divide by zero); sampled with value.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new display outputs are valid.
- digits  out  4*DIGITS  BCD digit codes; digit i is bits [4i+3:4i], i=0 is the least significant.
- off_bits  out  DIGITS  per-digit blank flag.
- err_bits  out  DIGITS  per-digit error flag.

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-low; rst_n=0 at a rising edge forces reset state regardless of other inputs, including mid-conversion. No partial result is published.
- Reset values:
  - busy=0, done=0, digits=0, err_bits=0.
  - off_bits: all 1 except bit 0 = 0, so the display shows a single "0".
  - FSM enters IDLE; shift counter=0.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 loads the shift register with value and clears the internal BCD register (4*(DIGITS+1) bits, one guard digit).
  - Latches err_in, sets busy=1 on the next edge, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, one iteration per clock, IN_W cycles:
  - Every BCD nibble >= 5 gets +3 first.
  - Then {bcd, shift_reg} shifts left by 1.
  - Counter increments; at count IN_W-1 go to FINISH.
- FINISH, one cycle:
  - Register the outputs, pulse done=1, clear busy, return to IDLE.
- Latency: start accepted at edge N, so done=1 and the new outputs are visible after edge N+IN_W+1 (17 cycles for IN_W=16). Latency is constant regardless of value or err_in.
- Outputs are registered and change only in FINISH. The previous display holds throughout a conversion, so there is no flicker.
- Overflow: guard digit nonzero (value > 10^DIGITS-1) sets the error condition.
- Error condition (overflow OR latched err_in):
  - err_bits all 1, off_bits all 0, digits all 0.
- Normal case:
  - digits = low DIGITS nibbles of BCD; err_bits=0.
  - off_bits[i]=1 iff i>0 and digits i..DIGITS-1 are all zero. Bit 0 is never blanked.
- start while busy (SHIFT or FINISH) is ignored, with no queueing. start in the same cycle as FINISH is also ignored.
- done returns to 0 the cycle after FINISH. start on that next cycle is accepted normally.
- value and err_in may change freely after acceptance without affecting the conversion in flight.

Test Plan:
- Reset then idle 5 cycles: digits=0x0000, off_bits=4'b1110, err_bits=0, busy=0, done never pulses.
- value=1234, start 1 cycle: busy for 17 cycles, done pulse exactly 17 cycles after start; digits=0x1234, off_bits=4'b0000.
- value=7: digits=0x0007, off_bits=4'b1110. value=0: off_bits=4'b1110, digit0=0. value=305: digits=0x0305, off_bits=4'b1000 (inner zero kept).
- value=10000 and value=65535: err_bits=4'b1111, off_bits=0, digits=0. value=9999: no error, digits=0x9999.
- err_in=1 with value=42: err_bits=4'b1111 after 17 cycles. Following start with err_in=0, value=42: digits=0x0042, off_bits=4'b1100, err_bits=0.
- Concurrency and reset mid-operation:
  - start with value=11, then start with value=99 at cycle 5 and again on the FINISH cycle: only 11 is displayed, one done pulse.
  - rst_n=0 at cycle 8 of a conversion: next edge shows reset values, no done.
  - A new start after reset converts correctly.
